br_perf_counter: RTL and testbench

//  - Event counter inside the branch functional unit. Consumes per-cycle branch-resolution events and produces the

---
 rtl/br_perf_counter_pkg.sv | 25 ++
 rtl/br_perf_counter_if.sv | 71 +++++++
 rtl/br_perf_counter_sat_counter.sv | 41 ++++
 rtl/br_perf_counter.sv | 227 ++++++++++++++++++++++
 tb/tb_br_perf_counter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/br_perf_counter_pkg.sv
// ----------------------------------------------------------------------------
// perf_pkg
// Shared types for the branch-unit performance counter slice.
//   br_type_t    : class of a resolved branch (conditional, JAL, JALR)
//   perf_state_t : counter control state as seen on perf_state
//   PERF_CNT_W   : default width of the cumulative counters
// ----------------------------------------------------------------------------
package perf_pkg;

   localparam int PERF_CNT_W = 32;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2
   } br_type_t;

   typedef enum logic [1:0] {
      PERF_IDLE   = 2'd0,
      PERF_COUNT  = 2'd1,
      PERF_FROZEN = 2'd2,
      PERF_SAT    = 2'd3
   } perf_state_t;

endpackage

// File: rtl/br_perf_counter_if.sv
// ----------------------------------------------------------------------------
// br_perf_counter_if
// Bundles the control inputs, branch-resolution event inputs and counter
// outputs of br_perf_counter.
//   master : the side that drives control/events and reads the counters
//   slave  : the counter block itself
// Optional macro BR_PERF_PER_TYPE_EN adds the per-type counter outputs
// perf_br_cond_cnt / perf_br_jal_cnt / perf_br_jalr_cnt.
// Parameters: CNT_W (cumulative counter width), WIN_W (window count width).
// ----------------------------------------------------------------------------
interface br_perf_counter_if #(
   parameter int CNT_W = perf_pkg::PERF_CNT_W,
   parameter int WIN_W = 9
);
   import perf_pkg::*;

   logic             perf_en;
   logic             perf_freeze;
   logic             perf_clear;
   logic             br_resolve_valid;
   br_type_t         br_resolve_type;
   logic             br_resolve_mispredict;

   logic [CNT_W-1:0] perf_br_cnt;
   logic [CNT_W-1:0] perf_br_mispredict_cnt;
   logic             perf_win_valid;
   logic [WIN_W-1:0] perf_win_mispredict_cnt;
   logic [1:0]       perf_state;
   logic             perf_saturated;

`ifdef BR_PERF_PER_TYPE_EN
   logic [CNT_W-1:0] perf_br_cond_cnt;
   logic [CNT_W-1:0] perf_br_jal_cnt;
   logic [CNT_W-1:0] perf_br_jalr_cnt;

   modport master (
      output perf_en, perf_freeze, perf_clear,
      output br_resolve_valid, br_resolve_type, br_resolve_mispredict,
      input  perf_br_cnt, perf_br_mispredict_cnt,
      input  perf_win_valid, perf_win_mispredict_cnt,
      input  perf_state, perf_saturated,
      input  perf_br_cond_cnt, perf_br_jal_cnt, perf_br_jalr_cnt
   );

   modport slave (
      input  perf_en, perf_freeze, perf_clear,
      input  br_resolve_valid, br_resolve_type, br_resolve_mispredict,
      output perf_br_cnt, perf_br_mispredict_cnt,
      output perf_win_valid, perf_win_mispredict_cnt,
      output perf_state, perf_saturated,
      output perf_br_cond_cnt, perf_br_jal_cnt, perf_br_jalr_cnt
   );
`else
   modport master (
      output perf_en, perf_freeze, perf_clear,
      output br_resolve_valid, br_resolve_type, br_resolve_mispredict,
      input  perf_br_cnt, perf_br_mispredict_cnt,
      input  perf_win_valid, perf_win_mispredict_cnt,
      input  perf_state, perf_saturated
   );

   modport slave (
      input  perf_en, perf_freeze, perf_clear,
      input  br_resolve_valid, br_resolve_type, br_resolve_mispredict,
      output perf_br_cnt, perf_br_mispredict_cnt,
      output perf_win_valid, perf_win_mispredict_cnt,
      output perf_state, perf_saturated
   );
`endif

endinterface

// File: rtl/br_perf_counter_sat_counter.sv
// ----------------------------------------------------------------------------
// perf_sat_counter
// Saturating up-counter used for every cumulative performance total.
//   clk      : clock
//   rst_n    : asynchronous active-low reset, zeroes the count
//   i_inc    : request to add one this cycle
//   i_clear  : synchronous clear, wins over i_inc
//   i_hold   : blocks the increment (frozen, not counting, or saturating)
//   o_count  : current count
//   o_at_max : count is all ones; further increments are ignored
// ----------------------------------------------------------------------------
module perf_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clear,
   input  logic         i_hold,
   output logic [W-1:0] o_count,
   output logic         o_at_max
);

   logic [W-1:0] r_count;

   // Count register: clear has priority, then a held or maxed-out counter
   // simply keeps its value rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && !i_hold && !o_at_max) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count  = r_count;
   assign o_at_max = &r_count;

endmodule

// File: rtl/br_perf_counter.sv
// ----------------------------------------------------------------------------
// br_perf_counter
// Counts committed branch resolutions and mispredicts for the branch unit,
// and reports the mispredict count of every WINDOW_LEN-branch window.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : br_perf_counter_if.slave
//          in : perf_en, perf_freeze, perf_clear, br_resolve_valid,
//               br_resolve_type, br_resolve_mispredict
//          out: perf_br_cnt, perf_br_mispredict_cnt, perf_win_valid,
//               perf_win_mispredict_cnt, perf_state, perf_saturated
// Optional macro BR_PERF_PER_TYPE_EN: adds per-type totals
// (perf_br_cond_cnt / perf_br_jal_cnt / perf_br_jalr_cnt) that follow the
// same count/freeze/clear/saturation rules as perf_br_cnt.
// ----------------------------------------------------------------------------
module br_perf_counter
   import perf_pkg::*;
#(
   parameter int CNT_W      = PERF_CNT_W,
   parameter int WINDOW_LEN = 256,
   parameter int WIN_W      = $clog2(WINDOW_LEN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   br_perf_counter_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = PERF_IDLE;
   localparam logic [1:0] S_COUNT  = PERF_COUNT;
   localparam logic [1:0] S_FROZEN = PERF_FROZEN;
   localparam logic [1:0] S_SAT    = PERF_SAT;

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_saturated;

   logic [WIN_W-1:0] r_win_br_cnt;
   logic [WIN_W-1:0] r_win_mp_cnt;
   logic [WIN_W-1:0] r_win_mp_out;
   logic             r_win_valid;

   logic             w_event;
   logic             w_overflow;
   logic             w_accept;
   logic             w_hold;
   logic             w_any_max;
   logic             w_type_at_max;
   logic [WIN_W-1:0] w_mp_ext;

   logic [CNT_W-1:0] w_br_cnt;
   logic [CNT_W-1:0] w_mp_cnt;
   logic             w_br_at_max;
   logic             w_mp_at_max;

   // An event is a candidate for counting only while COUNT is the current
   // state; a simultaneous clear drops it.
   assign w_event  = (r_state == S_COUNT) && bus.br_resolve_valid && !bus.perf_clear;
   assign w_mp_ext = {{(WIN_W-1){1'b0}}, bus.br_resolve_mispredict};

   // Overflow of any counter this event would touch blocks every counter, so
   // the mispredict/total ratio and the per-type sum stay consistent.
   assign w_any_max  = w_br_at_max
                     | (bus.br_resolve_mispredict & w_mp_at_max)
                     | w_type_at_max;
   assign w_overflow = w_event && w_any_max;
   assign w_accept   = w_event && !w_overflow;
   assign w_hold     = w_overflow || (r_state != S_COUNT);

   perf_sat_counter #(.W(CNT_W)) u_br_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .i_inc    (w_event),
      .i_clear  (bus.perf_clear),
      .i_hold   (w_hold),
      .o_count  (w_br_cnt),
      .o_at_max (w_br_at_max)
   );

   perf_sat_counter #(.W(CNT_W)) u_mp_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .i_inc    (w_event && bus.br_resolve_mispredict),
      .i_clear  (bus.perf_clear),
      .i_hold   (w_hold),
      .o_count  (w_mp_cnt),
      .o_at_max (w_mp_at_max)
   );

`ifdef BR_PERF_PER_TYPE_EN
   logic [CNT_W-1:0] w_cond_cnt;
   logic [CNT_W-1:0] w_jal_cnt;
   logic [CNT_W-1:0] w_jalr_cnt;
   logic             w_cond_at_max;
   logic             w_jal_at_max;
   logic             w_jalr_at_max;
   logic             w_is_cond;
   logic             w_is_jal;
   logic             w_is_jalr;

   assign w_is_cond = (bus.br_resolve_type == BR_COND);
   assign w_is_jal  = (bus.br_resolve_type == BR_JAL);
   assign w_is_jalr = (bus.br_resolve_type == BR_JALR);

   assign w_type_at_max = (w_is_cond & w_cond_at_max)
                        | (w_is_jal  & w_jal_at_max)
                        | (w_is_jalr & w_jalr_at_max);

   perf_sat_counter #(.W(CNT_W)) u_cond_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .i_inc    (w_event && w_is_cond),
      .i_clear  (bus.perf_clear),
      .i_hold   (w_hold),
      .o_count  (w_cond_cnt),
      .o_at_max (w_cond_at_max)
   );

   perf_sat_counter #(.W(CNT_W)) u_jal_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .i_inc    (w_event && w_is_jal),
      .i_clear  (bus.perf_clear),
      .i_hold   (w_hold),
      .o_count  (w_jal_cnt),
      .o_at_max (w_jal_at_max)
   );

   perf_sat_counter #(.W(CNT_W)) u_jalr_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .i_inc    (w_event && w_is_jalr),
      .i_clear  (bus.perf_clear),
      .i_hold   (w_hold),
      .o_count  (w_jalr_cnt),
      .o_at_max (w_jalr_at_max)
   );

   assign bus.perf_br_cond_cnt = w_cond_cnt;
   assign bus.perf_br_jal_cnt  = w_jal_cnt;
   assign bus.perf_br_jalr_cnt = w_jalr_cnt;
`else
   assign w_type_at_max = 1'b0;
`endif

   // Next-state logic. Clear beats everything; inside COUNT an overflowing
   // event beats the enable/freeze controls so saturation is never missed.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.perf_clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.perf_en) w_state_nxt = S_COUNT;
            end
            S_COUNT: begin
               if (w_overflow)            w_state_nxt = S_SAT;
               else if (!bus.perf_en)     w_state_nxt = S_IDLE;
               else if (bus.perf_freeze)  w_state_nxt = S_FROZEN;
            end
            S_FROZEN: begin
               if (!bus.perf_en)          w_state_nxt = S_IDLE;
               else if (!bus.perf_freeze) w_state_nxt = S_COUNT;
            end
            S_SAT: begin
               w_state_nxt = S_SAT;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and sticky saturation flag; the flag only falls on clear/reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_saturated <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (bus.perf_clear)  r_saturated <= 1'b0;
         else if (w_overflow) r_saturated <= 1'b1;
      end
   end

   // Window tracking. The window counters only move on accepted events, so
   // they naturally hold through IDLE/FROZEN. On the closing event the
   // published count includes that event's own mispredict bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win_br_cnt <= '0;
         r_win_mp_cnt <= '0;
         r_win_mp_out <= '0;
         r_win_valid  <= 1'b0;
      end else if (bus.perf_clear) begin
         r_win_br_cnt <= '0;
         r_win_mp_cnt <= '0;
         r_win_mp_out <= '0;
         r_win_valid  <= 1'b0;
      end else begin
         r_win_valid <= 1'b0;
         if (w_accept) begin
            if (r_win_br_cnt == WIN_LAST) begin
               r_win_mp_out <= r_win_mp_cnt + w_mp_ext;
               r_win_valid  <= 1'b1;
               r_win_br_cnt <= '0;
               r_win_mp_cnt <= '0;
            end else begin
               r_win_br_cnt <= r_win_br_cnt + {{(WIN_W-1){1'b0}}, 1'b1};
               r_win_mp_cnt <= r_win_mp_cnt + w_mp_ext;
            end
         end
      end
   end

   assign bus.perf_br_cnt             = w_br_cnt;
   assign bus.perf_br_mispredict_cnt  = w_mp_cnt;
   assign bus.perf_win_valid          = r_win_valid;
   assign bus.perf_win_mispredict_cnt = r_win_mp_out;
   assign bus.perf_state              = r_state;
   assign bus.perf_saturated          = r_saturated;

endmodule

// File: tb/tb_br_perf_counter.sv
// ----------------------------------------------------------------------------
// tb_br_perf_counter
// Directed bench for br_perf_counter with a small configuration
// (CNT_W=4, WINDOW_LEN=4) so windows and saturation are reached quickly.
// Define BR_PERF_PER_TYPE_EN to also exercise the per-type totals.
// ----------------------------------------------------------------------------
module tb_br_perf_counter;
   import perf_pkg::*;

   localparam int CNT_W      = 4;
   localparam int WINDOW_LEN = 4;
   localparam int WIN_W      = 3;

   logic clk;
   logic rst;

   int testsRun;
   int testsFailed;

   br_perf_counter_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

   br_perf_counter #(
      .CNT_W      (CNT_W),
      .WINDOW_LEN (WINDOW_LEN),
      .WIN_W      (WIN_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge happen, then settle 1 unit past
   // it so the caller samples registered outputs away from the edge.
   task automatic applyStimulus(input logic en, input logic freeze, input logic clear,
                                input logic valid, input logic [1:0] typ, input logic mp);
      bus.perf_en               = en;
      bus.perf_freeze           = freeze;
      bus.perf_clear            = clear;
      bus.br_resolve_valid      = valid;
      bus.br_resolve_type       = br_type_t'(typ);
      bus.br_resolve_mispredict = mp;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      logic [9:0] mpPat;
      logic [1:0] typSeq [6];

      testsRun    = 0;
      testsFailed = 0;
      mpPat       = 10'b00_0000_1101;
      typSeq      = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};

      // Reset state
      rst                       = 1'b0;
      bus.perf_en               = 1'b0;
      bus.perf_freeze           = 1'b0;
      bus.perf_clear            = 1'b0;
      bus.br_resolve_valid      = 1'b0;
      bus.br_resolve_type       = BR_COND;
      bus.br_resolve_mispredict = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_br_cnt",  32'(bus.perf_br_cnt), 32'd0);
      checkOutput("rst_mp_cnt",  32'(bus.perf_br_mispredict_cnt), 32'd0);
      checkOutput("rst_state",   32'(bus.perf_state), 32'd0);
      checkOutput("rst_win_vld", 32'(bus.perf_win_valid), 32'd0);
      checkOutput("rst_win_cnt", 32'(bus.perf_win_mispredict_cnt), 32'd0);
      checkOutput("rst_sat",     32'(bus.perf_saturated), 32'd0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      // Event in the cycle perf_en rises is not counted (still IDLE)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("arm_state",  32'(bus.perf_state), 32'd1);
      checkOutput("arm_br_cnt", 32'(bus.perf_br_cnt), 32'd0);

      // 10 events, mispredicts 1,0,1,1 then zeros: windows close after 4 and 8
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, mpPat[i]);
         if (i == 3) begin
            checkOutput("win1_vld", 32'(bus.perf_win_valid), 32'd1);
            checkOutput("win1_cnt", 32'(bus.perf_win_mispredict_cnt), 32'd3);
         end
         if (i == 4) begin
            checkOutput("win1_vld_drop", 32'(bus.perf_win_valid), 32'd0);
            checkOutput("win1_cnt_hold", 32'(bus.perf_win_mispredict_cnt), 32'd3);
         end
         if (i == 7) begin
            checkOutput("win2_vld", 32'(bus.perf_win_valid), 32'd1);
            checkOutput("win2_cnt", 32'(bus.perf_win_mispredict_cnt), 32'd0);
         end
      end
      checkOutput("cnt10_br",    32'(bus.perf_br_cnt), 32'd10);
      checkOutput("cnt10_mp",    32'(bus.perf_br_mispredict_cnt), 32'd3);
      checkOutput("cnt10_state", 32'(bus.perf_state), 32'd1);

      // Freeze rises with an event: that event counts, next 5 do not
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("frz_edge_br",  32'(bus.perf_br_cnt), 32'd11);
      checkOutput("frz_edge_mp",  32'(bus.perf_br_mispredict_cnt), 32'd4);
      checkOutput("frz_state",    32'(bus.perf_state), 32'd2);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("frz_hold_br",  32'(bus.perf_br_cnt), 32'd11);
      checkOutput("frz_hold_mp",  32'(bus.perf_br_mispredict_cnt), 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("unfrz_state",  32'(bus.perf_state), 32'd1);
      // Window held 3 branches / 1 mispredict across FROZEN; this closes it
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      checkOutput("resume_br",    32'(bus.perf_br_cnt), 32'd12);
      checkOutput("win3_vld",     32'(bus.perf_win_valid), 32'd1);
      checkOutput("win3_cnt",     32'(bus.perf_win_mispredict_cnt), 32'd1);

      // Clear with a simultaneous event
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
      checkOutput("clr_br",    32'(bus.perf_br_cnt), 32'd0);
      checkOutput("clr_state", 32'(bus.perf_state), 32'd0);
      checkOutput("clr_win",   32'(bus.perf_win_mispredict_cnt), 32'd0);

      // Count to 7, then clear on the event that would close the window
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("pre_clr_br", 32'(bus.perf_br_cnt), 32'd7);
      checkOutput("pre_clr_mp", 32'(bus.perf_br_mispredict_cnt), 32'd7);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
      checkOutput("clr7_br",      32'(bus.perf_br_cnt), 32'd0);
      checkOutput("clr7_mp",      32'(bus.perf_br_mispredict_cnt), 32'd0);
      checkOutput("clr7_win_vld", 32'(bus.perf_win_valid), 32'd0);
      checkOutput("clr7_state",   32'(bus.perf_state), 32'd0);

      // Saturation: 15 events reach max, 16th saturates
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("max_br",    32'(bus.perf_br_cnt), 32'd15);
      checkOutput("max_sat",   32'(bus.perf_saturated), 32'd0);
      checkOutput("max_state", 32'(bus.perf_state), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("sat_br",      32'(bus.perf_br_cnt), 32'd15);
      checkOutput("sat_mp",      32'(bus.perf_br_mispredict_cnt), 32'd15);
      checkOutput("sat_flag",    32'(bus.perf_saturated), 32'd1);
      checkOutput("sat_state",   32'(bus.perf_state), 32'd3);
      checkOutput("sat_win_vld", 32'(bus.perf_win_valid), 32'd0);
      checkOutput("sat_win_cnt", 32'(bus.perf_win_mispredict_cnt), 32'd4);
      // Dropping perf_en does not leave SAT
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      checkOutput("sat_sticky", 32'(bus.perf_state), 32'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("satclr_br",    32'(bus.perf_br_cnt), 32'd0);
      checkOutput("satclr_mp",    32'(bus.perf_br_mispredict_cnt), 32'd0);
      checkOutput("satclr_sat",   32'(bus.perf_saturated), 32'd0);
      checkOutput("satclr_state", 32'(bus.perf_state), 32'd0);

      // perf_en falls with an event in COUNT: counted, then back to IDLE
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      checkOutput("dis_br",    32'(bus.perf_br_cnt), 32'd1);
      checkOutput("dis_state", 32'(bus.perf_state), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      checkOutput("idle_br", 32'(bus.perf_br_cnt), 32'd1);
      checkOutput("idle_mp", 32'(bus.perf_br_mispredict_cnt), 32'd0);

      // Per-type totals: 2 COND, 3 JAL, 1 JALR
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, typSeq[i], 1'b0);
      checkOutput("type_br", 32'(bus.perf_br_cnt), 32'd6);
`ifdef BR_PERF_PER_TYPE_EN
      checkOutput("type_cond", 32'(bus.perf_br_cond_cnt), 32'd2);
      checkOutput("type_jal",  32'(bus.perf_br_jal_cnt),  32'd3);
      checkOutput("type_jalr", 32'(bus.perf_br_jalr_cnt), 32'd1);
`endif

      // Async reset mid-window: everything back to zero, no pulse
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_br",    32'(bus.perf_br_cnt), 32'd0);
      checkOutput("arst_state", 32'(bus.perf_state), 32'd0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("arst_win_vld", 32'(bus.perf_win_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
